knn_ctrl: RTL

Sequencer for the KNN `sorter` datapath. On a start command it latches a test point, clears the sorter, then streams N training points from a training-point memory into the sorter with correctly spaced `ready` pulses. It then asserts DONE, walks SEL over all K result registers, and packs the K nearest-neighbour labels into a result vector. It sits between the CPU-facing register bank and the `sorter` instance.

---
 rtl/knn_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/knn_ctrl.sv
`default_nettype none
// knn_ctrl: query sequencer for the KNN sorter. It clears the sorter, streams N points, then reads K labels.
// Optional feature: define KNN_CTRL_ABORT_EN to add the abort input.
module knn_ctrl #(
   parameter int DATA_W = 16,
   parameter int LBL_W  = 8,
   parameter int ADDR_W = 8,
   parameter int K      = 4,
   parameter int GAP    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
`ifdef KNN_CTRL_ABORT_EN
   input  logic                      abort,
`endif
   input  logic [ADDR_W:0]           n_points,
   input  logic signed [DATA_W-1:0]  test_x,
   input  logic signed [DATA_W-1:0]  test_y,
   output logic                      busy,
   output logic                      done,
   output logic                      res_valid,
   output logic [K*LBL_W-1:0]        res_lbl,
   output logic                      mem_rd_en,
   output logic [ADDR_W-1:0]         mem_addr,
   input  logic signed [DATA_W-1:0]  mem_x,
   input  logic signed [DATA_W-1:0]  mem_y,
   output logic                      srt_clr,
   output logic                      srt_ready,
   output logic                      srt_done,
   output logic [$clog2(K)-1:0]      srt_sel,
   output logic signed [DATA_W-1:0]  srt_x1,
   output logic signed [DATA_W-1:0]  srt_y1,
   output logic signed [DATA_W-1:0]  srt_x2,
   output logic signed [DATA_W-1:0]  srt_y2,
   input  logic [LBL_W-1:0]          srt_data_out
);

   localparam int CNT_W  = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam int SEL_W  = $clog2(K);
   localparam bit NO_GAP = (GAP == 0);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] CLEAR  = 3'd1;
   localparam logic [2:0] FETCH  = 3'd2;
   localparam logic [2:0] FEED   = 3'd3;
   localparam logic [2:0] WAIT   = 3'd4;
   localparam logic [2:0] READ   = 3'd5;
   localparam logic [2:0] FINISH = 3'd6;

   logic [2:0]               state;
   logic [ADDR_W:0]          n_lat;
   logic signed [DATA_W-1:0] tx_lat;
   logic signed [DATA_W-1:0] ty_lat;
   logic signed [DATA_W-1:0] x2_q;
   logic signed [DATA_W-1:0] y2_q;
   logic [ADDR_W-1:0]        idx;
   logic [CNT_W-1:0]         cnt;
   logic [SEL_W-1:0]         j;
   logic [K*LBL_W-1:0]       lbl_buf;
   logic                     fed;
   logic                     abort_req;
   logic                     gap_end;
   logic                     last_pt;

`ifdef KNN_CTRL_ABORT_EN
   assign abort_req = abort && (state != IDLE) && (state != FINISH);
`else
   assign abort_req = 1'b0;
`endif

   // The gap ends on the last WAIT cycle, or straight out of FEED when there is no gap.
   assign gap_end = ((state == WAIT) && (cnt == CNT_W'(1))) || ((state == FEED) && NO_GAP);
   assign last_pt = ({1'b0, idx} == (n_lat - 1'b1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         n_lat     <= '0;
         tx_lat    <= '0;
         ty_lat    <= '0;
         x2_q      <= '0;
         y2_q      <= '0;
         idx       <= '0;
         cnt       <= '0;
         j         <= '0;
         lbl_buf   <= '0;
         fed       <= 1'b0;
         res_lbl   <= '0;
         res_valid <= 1'b0;
      end else if (abort_req) begin
         state <= FINISH;
         fed   <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if ((state == FINISH) && fed) begin
                  res_lbl   <= lbl_buf;
                  res_valid <= 1'b1;
               end
               // A new start in the FINISH cycle is accepted and wins over the valid flag.
               if (start) begin
                  n_lat     <= n_points;
                  tx_lat    <= test_x;
                  ty_lat    <= test_y;
                  res_valid <= 1'b0;
                  fed       <= (n_points != '0);
                  state     <= (n_points != '0) ? CLEAR : FINISH;
               end else begin
                  state <= IDLE;
               end
            end
            CLEAR: begin
               idx   <= '0;
               state <= FETCH;
            end
            FETCH: begin
               state <= FEED;
            end
            FEED: begin
               x2_q  <= mem_x;
               y2_q  <= mem_y;
               cnt   <= CNT_W'(GAP);
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
            end
            READ: begin
               lbl_buf[int'(j)*LBL_W +: LBL_W] <= srt_data_out;
               if (j == SEL_W'(K - 1)) begin
                  state <= FINISH;
               end else begin
                  j <= j + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (gap_end) begin
            if (last_pt) begin
               state <= READ;
               j     <= '0;
            end else begin
               idx   <= idx + 1'b1;
               state <= FETCH;
            end
         end
      end
   end

   assign busy      = (state != IDLE) && (state != FINISH);
   assign done      = (state == FINISH);
   assign srt_clr   = (state == CLEAR);
   assign mem_rd_en = (state == FETCH);
   assign mem_addr  = idx;
   assign srt_ready = (state == FEED);
   assign srt_done  = (state == READ);
   assign srt_sel   = (state == READ) ? j : '0;
   assign srt_x1    = tx_lat;
   assign srt_y1    = ty_lat;
   // Memory data is presented to the sorter in the same cycle as the ready strobe.
   assign srt_x2    = (state == FEED) ? mem_x : x2_q;
   assign srt_y2    = (state == FEED) ? mem_y : y2_q;

endmodule
`default_nettype wire
